// File: rtl/fourbit_enc_ctrl.sv
// 4-to-2 encoder with a one-entry valid/ready output register and zero-vector counter.
// Define ROUND_ROBIN_EN to resolve multi-hot inputs round-robin instead of lowest-index-first.
module fourbit_enc_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       a_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       y_code,
  output logic             y_multi,
  output logic             y_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] zero_cnt,
  output logic             state_dbg
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // the producer holds its data stable until then, and the output register holds while stalled.
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e     state;
  logic       accept;
  logic [1:0] grant;
  logic       multi;
  logic       zero;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign multi     = (a_in & (a_in - 4'd1)) != 4'd0;
  assign zero      = (a_in == 4'd0);
  assign state_dbg = state;

`ifdef ROUND_ROBIN_EN
  logic [1:0] ptr;
  logic [1:0] idx;
  logic       found;

  // Search starts one past the last grant and wraps, so the last winner has lowest priority.
  always_comb begin
    grant = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && a_in[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
`else
  always_comb begin
    grant = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (a_in[i]) grant = 2'(i);
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      y_code    <= 2'd0;
      y_multi   <= 1'b0;
      y_zero    <= 1'b0;
      zero_cnt  <= '0;
`ifdef ROUND_ROBIN_EN
      ptr       <= 2'd3;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= FULL;
            out_valid <= 1'b1;
          end
        end
        FULL: begin
          if (!accept && out_ready) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
        end
      endcase

      if (accept) begin
        y_code  <= grant;
        y_multi <= multi;
        y_zero  <= zero;
        if (zero && (zero_cnt != {CNT_W{1'b1}})) zero_cnt <= zero_cnt + 1'b1;
`ifdef ROUND_ROBIN_EN
        if (!zero) ptr <= grant;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fourbit_enc_ctrl.sv
// Scoreboard bench for fourbit_enc_ctrl: directed vectors, expected {y_code,y_multi,y_zero}
// queued at accept and popped by a monitor on each output handshake.
module tb_fourbit_enc_ctrl;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [3:0]       a_in;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       y_code;
  logic             y_multi;
  logic             y_zero;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] zero_cnt;
  logic             state_dbg;

  logic [3:0] exp_q[$];
  int         pass_cnt  = 0;
  int         total_cnt = 0;

  fourbit_enc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y_code    (y_code),
    .y_multi   (y_multi),
    .y_zero    (y_zero),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .zero_cnt  (zero_cnt),
    .state_dbg (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Driver tasks
  task automatic send(input logic [3:0] a, input logic [3:0] exp);
    int n = 0;
    a_in     = a;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      total_cnt++;
      $display("FAIL send_timeout: in_ready stayed 0 for a_in=%b", a);
    end else begin
      exp_q.push_back(exp);
      @(posedge clk); #1;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a_in     = 4'd0;
  endtask

  // Scoreboard monitor: compares on every output handshake
  initial begin
    logic [3:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_output: got %0h with empty queue", {y_code, y_multi, y_zero});
        end else begin
          exp = exp_q.pop_front();
          check("result", {28'd0, y_code, y_multi, y_zero}, {28'd0, exp});
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; a_in = 4'd0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_y_code", {30'd0, y_code}, 32'd0);
    check("rst_zero_cnt", {24'd0, zero_cnt}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // One-hot sweep, back to back
    send(4'b0001, {2'd0, 1'b0, 1'b0});
    send(4'b0010, {2'd1, 1'b0, 1'b0});
    send(4'b0100, {2'd2, 1'b0, 1'b0});
    send(4'b1000, {2'd3, 1'b0, 1'b0});

    // Multi-hot 1010 twice; previous grant was index 3
    send(4'b1010, {2'd1, 1'b1, 1'b0});
`ifdef ROUND_ROBIN_EN
    send(4'b1010, {2'd3, 1'b1, 1'b0});
`else
    send(4'b1010, {2'd1, 1'b1, 1'b0});
`endif
    idle();
    repeat (2) @(posedge clk);
    #1;

    // Backpressure hold
    out_ready = 1'b0;
    send(4'b0100, {2'd2, 1'b0, 1'b0});
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_out_valid", {31'd0, out_valid}, 32'd1);
      check("hold_y_code", {30'd0, y_code}, 32'd2);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;

    // Zero vectors: counter saturates
    for (int i = 0; i < 260; i++) send(4'b0000, {2'd0, 1'b0, 1'b1});
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("zero_cnt_sat", {24'd0, zero_cnt}, 32'd255);

    // Reset while holding a result
    out_ready = 1'b0;
    send(4'b1000, {2'd3, 1'b0, 1'b0});
    idle();
    @(negedge clk);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_y_code", {30'd0, y_code}, 32'd3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_zero_cnt", {24'd0, zero_cnt}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_no_replay", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    send(4'b1111, {2'd0, 1'b1, 1'b0});
    idle();

    // Drain the scoreboard
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fourbit_enc_ctrl.md
FOURBIT_ENC_CTRL -- requirements
Module: fourbit_enc_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the width of the zero-input error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port a_in, input, 4 bits: request vector; one-hot nominal, multi-hot or zero legal.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a_in is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a_in this cycle.
REQ-007 The block SHALL have port y_code, output, 2 bits: the encoded index of the granted request bit.
REQ-008 The block SHALL have port y_multi, output, 1 bit: the accepted a_in had more than one bit set.
REQ-009 The block SHALL have port y_zero, output, 1 bit: the accepted a_in was 4'b0000.
REQ-010 The block SHALL have port out_valid, output, 1 bit: y_code, y_multi and y_zero are valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the output this cycle.
REQ-012 The block SHALL have port zero_cnt, output, CNT_W bits: count of accepted zero vectors.

Function
REQ-013 The block SHALL implement the inverse of the 2-to-4 one-hot decoder: for one-hot a_in = 4'b0001 << k, y_code SHALL be k.
REQ-014 The block SHALL use a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-016 An input SHALL be accepted when in_valid && in_ready; the result SHALL be registered with out_valid=1 on the next cycle, giving 1-cycle latency.
REQ-017 EMPTY SHALL go to FULL on accept.
REQ-018 FULL SHALL stay FULL on simultaneous out_ready and accept, with the new result loaded (full throughput).
REQ-019 FULL SHALL go to EMPTY on out_ready without accept.
REQ-020 While out_valid=1 && out_ready=0, all outputs SHALL hold stable.
REQ-021 y_multi SHALL be 1 iff popcount(a_in) >= 2.
REQ-022 y_zero SHALL be 1 iff a_in == 0; in that case y_code SHALL be 2'b00.
REQ-023 Zero-input results SHALL still be presented with out_valid=1.
REQ-024 zero_cnt SHALL increment by 1 on each accepted zero vector and saturate at all-ones with no wrap.
REQ-025 a_in SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-026 On rst_n=0, asynchronously: state EMPTY, out_valid=0, y_code=0, y_multi=0, y_zero=0, zero_cnt=0, round-robin pointer=3.
REQ-027 in_ready SHALL read 1 during and after reset.
REQ-028 A reset asserted mid-transfer SHALL discard the held result; nothing SHALL be replayed after reset release.

Configuration
REQ-029 With macro ROUND_ROBIN_EN undefined, multi-hot inputs SHALL be resolved by fixed priority: the lowest set index wins.
REQ-030 With ROUND_ROBIN_EN defined, the search SHALL start at (ptr+1) mod 4 and wrap; ptr SHALL be loaded with the granted index on every accepted non-zero input.
REQ-031 ptr SHALL be unchanged on zero inputs; one-hot results SHALL be identical in both builds.

Verification
REQ-032 The bench SHALL apply a_in = 0001, 0010, 0100, 1000, one per cycle, with out_ready=1 -> y_code = 0, 1, 2, 3 on consecutive cycles, y_multi=0, y_zero=0.
REQ-033 The bench SHALL accept a_in=0100 with out_ready=0 for 3 cycles -> out_valid=1, y_code=2 held, in_ready=0; then out_ready=1 -> out_valid=0 next cycle.
REQ-034 The bench SHALL accept a_in=0000 260 times with CNT_W=8 -> y_zero=1, y_code=0 each time, and zero_cnt ends at 255.
REQ-035 Without ROUND_ROBIN_EN, the bench SHALL apply a_in=1010 twice -> y_code=1 both times, y_multi=1; with ROUND_ROBIN_EN, the same stimulus -> y_code=1 then 3.
REQ-036 The bench SHALL hold out_valid=1, y_code=3, then pulse rst_n=0 for a half cycle -> out_valid=0 and zero_cnt=0 immediately; the first post-reset multi-hot a_in=1111 -> y_code=0 in both builds.
